// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive input sweeper for single-output circuits under screening.
// Captures a truth table, ones count and MISR signature per sweep.
module exhaustive_vector_sweeper #(
    parameter int              N_IN   = 3,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SIG_W-1:0]     golden_sig,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   truth_table,
    output logic [N_IN:0]        ones_count,
    output logic [SIG_W-1:0]     sig
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CAP_AT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_vec;
    logic [CW-1:0]     r_cnt;
    logic [NV-1:0]     r_tt;
    logic [N_IN:0]     r_ones;
    logic [SIG_W-1:0]  r_sig;
    logic [SIG_W-1:0]  w_sig_nx;
    logic              w_sweep;
    logic              w_go;
    logic              w_cap;
    logic              w_last;
    logic              w_busy;
    logic              w_done;

    assign w_sweep = (r_state == SWEEP);
    assign w_go    = start & ~w_sweep;
    assign w_cap   = w_sweep & ~abort & (r_cnt == CAP_AT);
    assign w_last  = &r_vec;

    // MISR step: shift, fold the polynomial on MSB carry-out, inject response
    assign w_sig_nx = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, dut_out};

    // State register
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; abort outranks both capture and start
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SWEEP;
            SWEEP: begin
                if (abort)                w_next = IDLE;
                else if (w_cap && w_last) w_next = DONE;
            end
            DONE:    if (start) w_next = SWEEP;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            SWEEP:   w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Sweep datapath: clear on start, record on capture, freeze otherwise
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_tt   <= '0;
            r_ones <= '0;
            r_sig  <= '0;
        end else if (w_go) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_tt   <= '0;
            r_ones <= '0;
            r_sig  <= '0;
        end else if (w_cap) begin
            r_tt[r_vec] <= dut_out;
            r_ones      <= r_ones + {{N_IN{1'b0}}, dut_out};
            r_sig       <= w_sig_nx;
            r_cnt       <= '0;
            if (!w_last) r_vec <= r_vec + N_IN'(1);
        end else if (w_sweep && !abort) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign vec_out     = r_vec;
    assign busy        = w_busy;
    assign done        = w_done;
    assign pass        = w_done & (r_sig == golden_sig);
    assign truth_table = r_tt;
    assign ones_count  = r_ones;
    assign sig         = r_sig;

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Bench for exhaustive_vector_sweeper: SETTLE=1 and SETTLE=3 instances
// checked against a vector-by-vector reference of the sweep results.
module tb_exhaustive_vector_sweeper;

    localparam logic [15:0] POLY = 16'h1021;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, abort1, start3, abort3;
    logic [15:0] golden;
    logic [7:0]  tbl1, tbl3;
    logic        glitch_en, glitch_val;

    logic        dut_out1, dut_out3;
    logic [2:0]  vec1, vec3;
    logic        busy1, busy3, done1, done3, pass1, pass3;
    logic [7:0]  tt1, tt3;
    logic [3:0]  ones1, ones3;
    logic [15:0] sig1, sig3;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    assign dut_out1 = tbl1[vec1];
    assign dut_out3 = glitch_en ? glitch_val : tbl3[vec3];

    exhaustive_vector_sweeper #(.N_IN(3), .SETTLE(1), .SIG_W(16), .POLY(POLY)) u_s1 (
        .CK(clk), .reset(rst_n), .start(start1), .abort(abort1),
        .golden_sig(golden), .dut_out(dut_out1), .vec_out(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
        .ones_count(ones1), .sig(sig1)
    );

    exhaustive_vector_sweeper #(.N_IN(3), .SETTLE(3), .SIG_W(16), .POLY(POLY)) u_s3 (
        .CK(clk), .reset(rst_n), .start(start3), .abort(abort3),
        .golden_sig(golden), .dut_out(dut_out3), .vec_out(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .truth_table(tt3),
        .ones_count(ones3), .sig(sig3)
    );

    // Reference signature: responses of the first n vectors fed in order
    function automatic logic [15:0] ref_sig(input logic [7:0] t, input int n);
        logic [15:0] s;
        logic        fb;
        s = '0;
        for (int i = 0; i < n; i++) begin
            fb = s[15];
            s  = s << 1;
            if (fb) s = s ^ POLY;
            s[0] = s[0] ^ t[i];
        end
        return s;
    endfunction

    function automatic int ref_ones(input logic [7:0] t, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(t[i]);
        return c;
    endfunction

    function automatic logic [7:0] parity_tbl();
        logic [7:0] t;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            t[i] = ^v;
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the SETTLE=1 instance with done-edge timing check
    task automatic sweep1(input logic [7:0] t, input string tag);
        tbl1   = t;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({tag, " busy"}, 32'(busy1), 32'd1);
        for (int i = 1; i < 8; i++) tick();
        chk({tag, " done_early"}, 32'(done1), 32'd0);
        tick();
        chk({tag, " done"}, 32'(done1), 32'd1);
        chk({tag, " busy_end"}, 32'(busy1), 32'd0);
        chk({tag, " tt"}, 32'(tt1), 32'(t));
        chk({tag, " ones"}, 32'(ones1), 32'(ref_ones(t, 8)));
        chk({tag, " sig"}, 32'(sig1), 32'(ref_sig(t, 8)));
        chk({tag, " vec"}, 32'(vec1), 32'd7);
    endtask

    // Full sweep on the SETTLE=3 instance; glitches off the capture edges
    task automatic sweep3(input logic [7:0] t, input string tag);
        int e;
        tbl3   = t;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            glitch_en  = (j % 3) != 0;
            glitch_val = 1'($urandom);
            tick();
            e = (j / 3 > 7) ? 7 : j / 3;
            chk({tag, " vec_step"}, 32'(vec3), 32'(e));
            if (j == 23) chk({tag, " done_early"}, 32'(done3), 32'd0);
        end
        glitch_en = 1'b0;
        chk({tag, " done"}, 32'(done3), 32'd1);
        chk({tag, " tt"}, 32'(tt3), 32'(t));
        chk({tag, " ones"}, 32'(ones3), 32'(ref_ones(t, 8)));
        chk({tag, " sig"}, 32'(sig3), 32'(ref_sig(t, 8)));
    endtask

    // Abort the SETTLE=1 instance after k captures
    task automatic abort_after(input logic [7:0] t, input int k, input string tag);
        logic [7:0] m;
        tbl1   = t;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < k; i++) tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        m = 8'((16'd1 << k) - 16'd1);
        chk({tag, " busy"}, 32'(busy1), 32'd0);
        chk({tag, " done"}, 32'(done1), 32'd0);
        chk({tag, " tt"}, 32'(tt1), 32'(t & m));
        chk({tag, " ones"}, 32'(ones1), 32'(ref_ones(t, k)));
        chk({tag, " sig"}, 32'(sig1), 32'(ref_sig(t, k)));
        chk({tag, " vec"}, 32'(vec1), 32'(k));
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] rt;
        int         k;
        par        = parity_tbl();
        rst_n      = 1'b0;
        start1     = 1'b0;
        abort1     = 1'b0;
        start3     = 1'b0;
        abort3     = 1'b0;
        golden     = 16'h0000;
        tbl1       = 8'h00;
        tbl3       = 8'h00;
        glitch_en  = 1'b0;
        glitch_val = 1'b0;
        tick();
        tick();

        chk("rst vec", 32'(vec1), 32'd0);
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        chk("rst pass", 32'(pass1), 32'd0);
        chk("rst tt", 32'(tt1), 32'd0);
        chk("rst ones", 32'(ones1), 32'd0);
        chk("rst sig", 32'(sig1), 32'd0);
        chk("rst3 busy", 32'(busy3), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle busy", 32'(busy1), 32'd0);

        sweep1(8'hFF, "T2");
        chk("T2 sig_const", 32'(sig1), 32'h00FF);
        chk("T2 ones_const", 32'(ones1), 32'd8);

        sweep1(par, "T3");
        chk("T3 tt_const", 32'(tt1), 32'h96);
        chk("T3 sig_const", 32'(sig1), 32'h0069);
        chk("T3 ones_const", 32'(ones1), 32'd4);
        golden = 16'h0069;
        #1;
        chk("T3 pass_hit", 32'(pass1), 32'd1);
        golden = 16'h0068;
        #1;
        chk("T3 pass_miss", 32'(pass1), 32'd0);
        golden = 16'h0069;
        tick();
        tick();
        tick();
        chk("hold done", 32'(done1), 32'd1);
        chk("hold sig", 32'(sig1), 32'h0069);
        chk("hold pass", 32'(pass1), 32'd1);

        for (int r = 0; r < 4; r++) begin
            rt = 8'($urandom);
            sweep1(rt, "rand1");
        end

        abort_after(par, 3, "T5");
        tick();
        tick();
        chk("T5 frozen_tt", 32'(tt1), 32'h06);
        chk("T5 frozen_ones", 32'(ones1), 32'd2);
        golden = 16'h0000;
        sweep1(par, "T5 rerun");

        for (int r = 0; r < 4; r++) begin
            rt = 8'($urandom);
            k  = int'($urandom_range(0, 7));
            abort_after(rt, k, "rabort");
        end

        // start pulsed mid-sweep is ignored
        tbl1   = par;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            start1 = (i == 3);
            tick();
        end
        start1 = 1'b0;
        chk("T6 done", 32'(done1), 32'd1);
        chk("T6 tt", 32'(tt1), 32'h96);
        chk("T6 sig", 32'(sig1), 32'h0069);

        // start and abort together mid-sweep: abort wins
        tbl1   = 8'hFF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        chk("T6 sa busy", 32'(busy1), 32'd0);
        chk("T6 sa done", 32'(done1), 32'd0);
        chk("T6 sa vec", 32'(vec1), 32'd1);
        chk("T6 sa tt", 32'(tt1), 32'h01);

        sweep3(par, "T4");
        chk("T4 sig_const", 32'(sig3), 32'h0069);
        rt = 8'($urandom);
        sweep3(rt, "T4 rand");

        // asynchronous reset in the middle of a sweep
        tbl1   = 8'hFF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("T1 vec", 32'(vec1), 32'd0);
        chk("T1 busy", 32'(busy1), 32'd0);
        chk("T1 done", 32'(done1), 32'd0);
        chk("T1 tt", 32'(tt1), 32'd0);
        chk("T1 ones", 32'(ones1), 32'd0);
        chk("T1 sig", 32'(sig1), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("T1 idle busy", 32'(busy1), 32'd0);
        chk("T1 idle vec", 32'(vec1), 32'd0);
        sweep1(par, "T1 after");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
